// File: rtl/cla_pkg.sv
// Shared constants, types and parameter checks for the pipelined carry-lookahead adder.
// Used by cla_group4 and cla_pipe_adder (flag logic there is gated by CLA_PIPE_FLAGS_EN).
package cla_pkg;

  localparam int CLA_GROUP_W        = 4;
  localparam int CLA_DEFAULT_WIDTH  = 32;
  localparam int CLA_DEFAULT_STAGES = 2;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic int claSegWidth(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit claParamsLegal(input int width, input int stages);
    return (stages >= 1) && (stages <= 8) && (width > 0) &&
           ((width % (CLA_GROUP_W * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: bit and group propagate/generate, sum from carry-in.
// Group P/G does not depend on cin_i, so callers can ripple group carries without a combinational loop.
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a_i,
  input  logic [CLA_GROUP_W-1:0] b_i,
  input  logic                   cin_i,
  output logic [CLA_GROUP_W-1:0] sum_o,
  output cla_pg_t                pg_o
);

  cla_pg_t [CLA_GROUP_W-1:0] bitPg;
  logic    [CLA_GROUP_W-1:0] carry;

  always_comb begin
    for (int i = 0; i < CLA_GROUP_W; i++) begin
      bitPg[i].p = a_i[i] ^ b_i[i];
      bitPg[i].g = a_i[i] & b_i[i];
    end
    pg_o.p = bitPg[3].p & bitPg[2].p & bitPg[1].p & bitPg[0].p;
    pg_o.g = bitPg[3].g
           | (bitPg[3].p & bitPg[2].g)
           | (bitPg[3].p & bitPg[2].p & bitPg[1].g)
           | (bitPg[3].p & bitPg[2].p & bitPg[1].p & bitPg[0].g);
  end

  always_comb begin
    carry[0] = cin_i;
    carry[1] = bitPg[0].g | (bitPg[0].p & cin_i);
    carry[2] = bitPg[1].g | (bitPg[1].p & bitPg[0].g) | (bitPg[1].p & bitPg[0].p & cin_i);
    carry[3] = bitPg[2].g | (bitPg[2].p & bitPg[1].g) | (bitPg[2].p & bitPg[1].p & bitPg[0].g)
             | (bitPg[2].p & bitPg[1].p & bitPg[0].p & cin_i);
    for (int i = 0; i < CLA_GROUP_W; i++) begin
      sum_o[i] = bitPg[i].p ^ carry[i];
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake; one segment summed per stage.
// Define CLA_PIPE_FLAGS_EN to compute o_ovf/o_zero; otherwise both are tied to 0.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_DEFAULT_WIDTH,
  parameter int STAGES = CLA_DEFAULT_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int SEG    = claSegWidth(WIDTH, STAGES);
  localparam int GROUPS = SEG / CLA_GROUP_W;

  if (!claParamsLegal(WIDTH, STAGES)) begin : g_badParams
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES and STAGES must be 1..8");
  end

  // Index k of these arrays is what stage k consumes; index k+1 is what stage k registered.
  logic             en;
  logic [WIDTH-1:0] opA    [STAGES];
  logic [WIDTH-1:0] opB    [STAGES];
  logic [WIDTH-1:0] sumW   [STAGES+1];
  logic             carryW [STAGES+1];
  logic             validW [STAGES+1];

  assign en        = !o_valid || i_ready;
  assign o_ready   = en;
  assign opA[0]    = i_a;
  assign opB[0]    = i_sub ? ~i_b : i_b;
  assign carryW[0] = i_sub | i_cin;
  assign sumW[0]   = '0;
  assign validW[0] = i_valid;

`ifdef CLA_PIPE_FLAGS_EN
  logic flagOvf;
  logic flagZero;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_pg_t [GROUPS-1:0] groupPg;
    logic    [GROUPS:0]   groupCarry;
    logic    [SEG-1:0]    segSum;
    logic    [WIDTH-1:0]  stageSum_d;
    logic    [WIDTH-1:0]  stageSum_q;
    logic                 stageCout_q;
    logic                 stageValid_q;

    for (genvar j = 0; j < GROUPS; j++) begin : g_group
      cla_group4 u_group (
        .a_i   (opA[k][k*SEG + j*CLA_GROUP_W +: CLA_GROUP_W]),
        .b_i   (opB[k][k*SEG + j*CLA_GROUP_W +: CLA_GROUP_W]),
        .cin_i (groupCarry[j]),
        .sum_o (segSum[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .pg_o  (groupPg[j])
      );
    end

    always_comb begin
      groupCarry[0] = carryW[k];
      for (int j = 0; j < GROUPS; j++) begin
        groupCarry[j+1] = groupPg[j].g | (groupPg[j].p & groupCarry[j]);
      end
    end

    // Earlier segments arrive already summed; this stage only fills in its own slice.
    always_comb begin
      stageSum_d = sumW[k];
      stageSum_d[k*SEG +: SEG] = segSum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        stageValid_q <= 1'b0;
        stageSum_q   <= '0;
        stageCout_q  <= 1'b0;
      end else if (en) begin
        stageValid_q <= validW[k];
        stageSum_q   <= stageSum_d;
        stageCout_q  <= groupCarry[GROUPS];
      end
    end

    assign sumW[k+1]   = stageSum_q;
    assign carryW[k+1] = stageCout_q;
    assign validW[k+1] = stageValid_q;

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] skewA_q;
      logic [WIDTH-1:0] skewB_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          skewA_q <= '0;
          skewB_q <= '0;
        end else if (en) begin
          skewA_q <= opA[k];
          skewB_q <= opB[k];
        end
      end

      assign opA[k+1] = skewA_q;
      assign opB[k+1] = skewB_q;
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= (opA[k][WIDTH-1] == opB[k][WIDTH-1]) &&
                    (stageSum_d[WIDTH-1] != opA[k][WIDTH-1]);
          zero_q <= (stageSum_d == '0);
        end
      end

      assign flagOvf  = ovf_q;
      assign flagZero = zero_q;
    end
`endif
  end

  assign o_valid = validW[STAGES];
  assign o_sum   = sumW[STAGES];
  assign o_cout  = carryW[STAGES];

`ifdef CLA_PIPE_FLAGS_EN
  assign o_ovf  = flagOvf;
  assign o_zero = flagZero;
`else
  assign o_ovf  = 1'b0;
  assign o_zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: default 32/2 instance plus 64/4 and 16/1 instances.
// Flag expectations follow CLA_PIPE_FLAGS_EN (flags read as 0 when it is undefined).
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        inValid = 0, inCin = 0, inSub = 0, downReady = 1;
  logic [31:0] inA = '0, inB = '0;
  logic        outReady, outValid, outCout, outOvf, outZero;
  logic [31:0] outSum;

  logic        wValid = 0, wCin = 0, wSub = 0;
  logic [63:0] wA = '0, wB = '0;
  logic        wReady, wOutValid, wCout, wOvf, wZero;
  logic [63:0] wSum;

  logic        nValid = 0, nCin = 0, nSub = 0;
  logic [15:0] nA = '0, nB = '0;
  logic        nReady, nOutValid, nCout, nOvf, nZero;
  logic [15:0] nSum;

  logic        sideReady = 1'b1;

  cla_pipe_adder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(inValid), .o_ready(outReady),
    .i_a(inA), .i_b(inB), .i_cin(inCin), .i_sub(inSub),
    .o_valid(outValid), .i_ready(downReady), .o_sum(outSum),
    .o_cout(outCout), .o_ovf(outOvf), .o_zero(outZero)
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(4)) dutWide (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(wValid), .o_ready(wReady),
    .i_a(wA), .i_b(wB), .i_cin(wCin), .i_sub(wSub),
    .o_valid(wOutValid), .i_ready(sideReady), .o_sum(wSum),
    .o_cout(wCout), .o_ovf(wOvf), .o_zero(wZero)
  );

  cla_pipe_adder #(.WIDTH(16), .STAGES(1)) dutNarrow (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(nValid), .o_ready(nReady),
    .i_a(nA), .i_b(nB), .i_cin(nCin), .i_sub(nSub),
    .o_valid(nOutValid), .i_ready(sideReady), .o_sum(nSum),
    .o_cout(nCout), .o_ovf(nOvf), .o_zero(nZero)
  );

  function automatic res_t refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
    logic [63:0] mask, am, bb;
    logic [64:0] full;
    res_t r;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + {64'd0, (sub | cin)};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = FLAGS_ON && (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = FLAGS_ON && (r.sum == 64'd0);
    return r;
  endfunction

  function automatic res_t mk(input logic [63:0] sum, input logic cout, input logic ovf,
                              input logic zero);
    res_t r;
    r.sum  = sum;
    r.cout = cout;
    r.ovf  = ovf & FLAGS_ON;
    r.zero = zero & FLAGS_ON;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRes(input string tag, input logic v, input logic [63:0] sum,
                          input logic cout, input logic ovf, input logic zero, input res_t e);
    checkOutput({tag, ".valid"}, {63'd0, v}, 64'd1);
    checkOutput({tag, ".sum"}, sum, e.sum);
    checkOutput({tag, ".cout"}, {63'd0, cout}, {63'd0, e.cout});
    checkOutput({tag, ".ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
    checkOutput({tag, ".zero"}, {63'd0, zero}, {63'd0, e.zero});
  endtask

  task automatic checkMain(input string tag, input res_t e);
    checkRes(tag, outValid, {32'd0, outSum}, outCout, outOvf, outZero, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub);
    inA = a; inB = b; inCin = cin; inSub = sub; inValid = 1'b1;
  endtask

  res_t expS [16];
  res_t e64  [12];
  res_t e16  [12];

  initial begin
    // Asynchronous reset: every output must be zero while reset is held.
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset.valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset.sum",   {32'd0, outSum},   64'd0);
    checkOutput("reset.cout",  {63'd0, outCout},  64'd0);
    checkOutput("reset.ovf",   {63'd0, outOvf},   64'd0);
    checkOutput("reset.zero",  {63'd0, outZero},  64'd0);
    checkOutput("reset.wideValid",   {63'd0, wOutValid}, 64'd0);
    checkOutput("reset.narrowValid", {63'd0, nOutValid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("reset.ready", {63'd0, outReady}, 64'd1);

    // Carry out of the low segment must cross into the high segment.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    inValid = 1'b0;
    checkOutput("carry.notYet", {63'd0, outValid}, 64'd0);
    tick();
    checkMain("carry", mk(64'd0, 1'b1, 1'b0, 1'b1));
    tick();
    checkOutput("carry.noDup", {63'd0, outValid}, 64'd0);

    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    inValid = 1'b0; inSub = 1'b0;
    tick();
    checkMain("subOvf", mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));

    // Back-to-back stream: every cycle after the first result must carry the next one.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        expS[i] = refModel(32, {32'd0, inA}, {32'd0, inB}, inCin, inSub);
      end else begin
        inValid = 1'b0;
      end
      tick();
      if (i >= 1) checkMain($sformatf("stream%0d", i - 1), expS[i-1]);
    end
    tick();
    checkOutput("stream.drained", {63'd0, outValid}, 64'd0);

    // Backpressure with the pipe full: A at output, B in stage 0, C waiting.
    applyStimulus(32'd10, 32'd20, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd100, 32'd200, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd1000, 32'd2000, 1'b0, 1'b0);
    downReady = 1'b0;
    #1;
    checkOutput("hold.readyLow", {63'd0, outReady}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("hold%0d.ready", i), {63'd0, outReady}, 64'd0);
      checkMain($sformatf("hold%0d", i), mk(64'd30, 1'b0, 1'b0, 1'b0));
    end
    downReady = 1'b1;
    tick();
    inValid = 1'b0;
    checkMain("release.B", mk(64'd300, 1'b0, 1'b0, 1'b0));
    tick();
    checkMain("release.C", mk(64'd3000, 1'b0, 1'b0, 1'b0));
    tick();
    checkOutput("release.drained", {63'd0, outValid}, 64'd0);

    // Reset with two operations in flight.
    applyStimulus(32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd2, 32'd2, 1'b0, 1'b0);
    tick();
    inValid = 1'b0;
    checkMain("preReset", mk(64'd2, 1'b0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset.valid", {63'd0, outValid}, 64'd0);
    checkOutput("midReset.sum",   {32'd0, outSum},   64'd0);
    checkOutput("midReset.cout",  {63'd0, outCout},  64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("postReset.valid0", {63'd0, outValid}, 64'd0);
    tick();
    checkOutput("postReset.valid1", {63'd0, outValid}, 64'd0);
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b0);
    tick();
    inValid = 1'b0;
    tick();
    checkMain("postReset.add", mk(64'd12, 1'b0, 1'b0, 1'b0));

    // 64/4 (latency 4) and 16/1 (latency 1) instances; op 0 ripples a carry through every segment.
    for (int i = 0; i < 15; i++) begin
      if (i < 12) begin
        wA   = (i == 0) ? {64{1'b1}} : {$urandom, $urandom};
        wB   = (i == 0) ? 64'd1 : {$urandom, $urandom};
        wCin = i[0];
        wSub = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        wValid = 1'b1;
        e64[i] = refModel(64, wA, wB, wCin, wSub);
        nA   = (i == 0) ? 16'hFFFF : 16'($urandom);
        nB   = (i == 0) ? 16'h0001 : 16'($urandom);
        nCin = ~i[0];
        nSub = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        nValid = 1'b1;
        e16[i] = refModel(16, {48'd0, nA}, {48'd0, nB}, nCin, nSub);
      end else begin
        wValid = 1'b0;
        nValid = 1'b0;
      end
      tick();
      if (i >= 3) checkRes($sformatf("wide%0d", i - 3), wOutValid, wSum, wCout, wOvf, wZero, e64[i-3]);
      if (i < 12) checkRes($sformatf("narrow%0d", i), nOutValid, {48'd0, nSum}, nCout, nOvf, nZero, e16[i]);
    end
    checkOutput("narrow.drained", {63'd0, nOutValid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
